// File: rtl/macc_dot_sequencer.sv
//------------------------------------------------------------------------------
// Module      : macc_dot_sequencer
// Description : Streams operand-pair vectors into the 8x8->16 MAC and captures
//               each dot product with its term count on a valid/ready port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module macc_dot_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int CNT_W     = 8,
  parameter int MAX_TERMS = 255
) (
  input  logic              Clk,
  input  logic              aclr_n,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] mac_dataa,
  output logic [DATA_W-1:0] mac_datab,
  output logic              mac_clken,
  output logic              mac_sload,
  input  logic [ACC_W-1:0]  mac_result,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_trunc,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam logic [CNT_W-1:0] C_MAX_TERMS = CNT_W'(MAX_TERMS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_term_num;
  logic             r_trunc_flag;
  logic             w_xfer;
  logic             w_eov;
  logic             w_capture;

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  assign w_xfer   = in_valid & in_ready;

  // Ordinal of the pair being offered; IDLE always starts a fresh vector at 1.
  assign w_term_num = (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_eov      = in_last | (w_term_num == C_MAX_TERMS);

  always_comb begin
    w_state_nxt = r_state;
    mac_clken   = 1'b0;
    mac_dataa   = '0;
    mac_datab   = '0;
    mac_sload   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_xfer) begin
          mac_clken   = 1'b1;
          mac_dataa   = in_a;
          mac_datab   = in_b;
          mac_sload   = (r_state == ST_IDLE);
          w_state_nxt = w_eov ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        mac_clken   = 1'b1;
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!res_valid || res_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_trunc_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_cnt <= w_term_num;
      end
      if (w_xfer && w_eov) begin
        r_trunc_flag <= ~in_last;
      end
    end
  end

  // A capture on the same edge as a downstream accept overwrites and stays valid.
  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      res_data  <= '0;
      res_count <= '0;
      res_trunc <= 1'b0;
      res_valid <= 1'b0;
    end else if (w_capture) begin
      res_data  <= mac_result;
      res_count <= r_cnt;
      res_trunc <= r_trunc_flag;
      res_valid <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_macc_dot_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_macc_dot_sequencer
// Description : Directed bench for macc_dot_sequencer with a bit-exact MAC model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_macc_dot_sequencer;

  logic        Clk = 1'b0;
  logic        aclr_n;
  logic [7:0]  in_a       [2];
  logic [7:0]  in_b       [2];
  logic        in_valid   [2];
  logic        in_last    [2];
  logic        in_ready   [2];
  logic [7:0]  mac_dataa  [2];
  logic [7:0]  mac_datab  [2];
  logic        mac_clken  [2];
  logic        mac_sload  [2];
  logic [15:0] mac_result [2];
  logic [15:0] res_data   [2];
  logic [7:0]  res_count  [2];
  logic        res_trunc  [2];
  logic        res_valid  [2];
  logic        res_ready  [2];

  int   total = 0;
  int   bad   = 0;
  logic last_sload;

  always #5 Clk = ~Clk;

  macc_dot_sequencer #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .MAX_TERMS(255)) u_dut0 (
    .Clk(Clk), .aclr_n(aclr_n),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_valid(in_valid[0]), .in_last(in_last[0]),
    .in_ready(in_ready[0]),
    .mac_dataa(mac_dataa[0]), .mac_datab(mac_datab[0]), .mac_clken(mac_clken[0]),
    .mac_sload(mac_sload[0]), .mac_result(mac_result[0]),
    .res_data(res_data[0]), .res_count(res_count[0]), .res_trunc(res_trunc[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0])
  );

  macc_dot_sequencer #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .MAX_TERMS(4)) u_dut1 (
    .Clk(Clk), .aclr_n(aclr_n),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_valid(in_valid[1]), .in_last(in_last[1]),
    .in_ready(in_ready[1]),
    .mac_dataa(mac_dataa[1]), .mac_datab(mac_datab[1]), .mac_clken(mac_clken[1]),
    .mac_sload(mac_sload[1]), .mac_result(mac_result[1]),
    .res_data(res_data[1]), .res_count(res_count[1]), .res_trunc(res_trunc[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1])
  );

  // Exact MAC model: inputs registered on clken, accumulated one clken later.
  logic [7:0]  m_ra  [2];
  logic [7:0]  m_rb  [2];
  logic        m_rs  [2];
  logic [15:0] m_acc [2];

  always @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int d = 0; d < 2; d++) begin
        m_ra[d]  <= '0;
        m_rb[d]  <= '0;
        m_rs[d]  <= 1'b0;
        m_acc[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mac_clken[d]) begin
          m_ra[d]  <= mac_dataa[d];
          m_rb[d]  <= mac_datab[d];
          m_rs[d]  <= mac_sload[d];
          m_acc[d] <= m_rs[d] ? (16'(m_ra[d]) * 16'(m_rb[d]))
                              : (m_acc[d] + 16'(m_ra[d]) * 16'(m_rb[d]));
        end
      end
    end
  end

  assign mac_result[0] = m_acc[0];
  assign mac_result[1] = m_acc[1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one pair from a negedge; returns at the negedge after it transfers.
  task automatic put(input int d, input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    in_a[d]     = a;
    in_b[d]     = b;
    in_last[d]  = last;
    in_valid[d] = 1'b1;
    #1;
    while (!in_ready[d] && n < 20) begin
      @(negedge Clk);
      #1;
      n++;
    end
    total++;
    assert (n < 20) else begin
      bad++;
      $error("FAIL put_timeout: observed=%0d expected=<20", n);
    end
    last_sload = mac_sload[d];
    @(negedge Clk);
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
    in_a[d]     = '0;
    in_b[d]     = '0;
  endtask

  task automatic wait_res(input int d, input logic [15:0] e_data, input logic [7:0] e_cnt,
                          input logic e_trunc, output int n);
    n = 0;
    #1;
    while (!res_valid[d] && n < 600) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check("res_valid_seen", 32'(res_valid[d]), 32'd1);
    check("res_data", 32'(res_data[d]), 32'(e_data));
    check("res_count", 32'(res_count[d]), 32'(e_cnt));
    check("res_trunc", 32'(res_trunc[d]), 32'(e_trunc));
  endtask

  initial begin
    int          lat;
    logic [15:0] full_exp;

    aclr_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_a[d] = '0; in_b[d] = '0; in_valid[d] = 1'b0; in_last[d] = 1'b0;
      res_ready[d] = 1'b1;
    end
    repeat (3) @(negedge Clk);
    #1;
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_res_valid", 32'(res_valid[0]), 32'd0);
    check("rst_res_data", 32'(res_data[0]), 32'd0);
    check("rst_res_count", 32'(res_count[0]), 32'd0);
    check("rst_res_trunc", 32'(res_trunc[0]), 32'd0);
    check("rst_clken", 32'(mac_clken[0]), 32'd0);
    aclr_n = 1'b1;
    @(negedge Clk);

    // Back-to-back three-term vector: 16+16+16
    put(0, 8'd4, 8'd4, 1'b0);
    check("t2_sload_first", 32'(last_sload), 32'd1);
    put(0, 8'd8, 8'd2, 1'b0);
    check("t2_sload_second", 32'(last_sload), 32'd0);
    put(0, 8'd16, 8'd1, 1'b1);
    wait_res(0, 16'd48, 8'd3, 1'b0, lat);
    check("t2_latency", 32'(lat), 32'd2);
    @(negedge Clk);
    #1;
    check("t2_valid_drop", 32'(res_valid[0]), 32'd0);
    @(negedge Clk);

    // Single-term vector
    put(0, 8'd16, 8'd16, 1'b1);
    wait_res(0, 16'd256, 8'd1, 1'b0, lat);
    check("t3_latency", 32'(lat), 32'd2);
    @(negedge Clk);

    // One-cycle in_valid gap mid-vector
    put(0, 8'd16, 8'd8, 1'b0);
    #1;
    check("t3_gap_clken", 32'(mac_clken[0]), 32'd0);
    check("t3_gap_ready", 32'(in_ready[0]), 32'd1);
    @(negedge Clk);
    put(0, 8'd16, 8'd8, 1'b1);
    wait_res(0, 16'd256, 8'd2, 1'b0, lat);
    @(negedge Clk);

    // MAX_TERMS=4 forced end, then a normal two-term vector
    for (int i = 0; i < 4; i++) put(1, 8'd4, 8'd4, 1'b0);
    wait_res(1, 16'd64, 8'd4, 1'b1, lat);
    @(negedge Clk);
    put(1, 8'd4, 8'd4, 1'b0);
    put(1, 8'd4, 8'd4, 1'b1);
    wait_res(1, 16'd32, 8'd2, 1'b0, lat);
    @(negedge Clk);

    // Backpressure: second vector stalls in CAPTURE
    res_ready[0] = 1'b0;
    put(0, 8'd16, 8'd1, 1'b1);
    put(0, 8'd32, 8'd1, 1'b1);
    repeat (2) @(negedge Clk);
    #1;
    check("t5_stall_ready", 32'(in_ready[0]), 32'd0);
    check("t5_stall_valid", 32'(res_valid[0]), 32'd1);
    check("t5_hold_data", 32'(res_data[0]), 32'd16);
    check("t5_stall_clken", 32'(mac_clken[0]), 32'd0);
    @(negedge Clk);
    #1;
    check("t5_hold_data2", 32'(res_data[0]), 32'd16);
    check("t5_stall_ready2", 32'(in_ready[0]), 32'd0);
    res_ready[0] = 1'b1;
    @(negedge Clk);
    #1;
    check("t5_second_data", 32'(res_data[0]), 32'd32);
    check("t5_second_valid", 32'(res_valid[0]), 32'd1);
    @(negedge Clk);
    #1;
    check("t5_final_valid", 32'(res_valid[0]), 32'd0);
    check("t5_final_ready", 32'(in_ready[0]), 32'd1);
    @(negedge Clk);

    // Reset in the middle of a vector
    put(0, 8'd16, 8'd1, 1'b0);
    put(0, 8'd16, 8'd1, 1'b0);
    aclr_n = 1'b0;
    #1;
    check("t1_rst_ready", 32'(in_ready[0]), 32'd1);
    check("t1_rst_valid", 32'(res_valid[0]), 32'd0);
    check("t1_rst_count", 32'(res_count[0]), 32'd0);
    @(negedge Clk);
    aclr_n = 1'b1;
    @(negedge Clk);
    put(0, 8'd16, 8'd2, 1'b1);
    check("t1_sload_after_rst", 32'(last_sload), 32'd1);
    wait_res(0, 16'd32, 8'd1, 1'b0, lat);
    @(negedge Clk);

    // Full-scale: 255 x (255*255), wrapped to 16 bits
    full_exp = '0;
    for (int i = 0; i < 255; i++) full_exp = full_exp + 16'd65025;
    for (int i = 0; i < 255; i++) put(0, 8'd255, 8'd255, (i == 254));
    wait_res(0, full_exp, 8'd255, 1'b0, lat);
    check("t6_latency", 32'(lat), 32'd2);
    @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
